// File: rtl/hybrid_brent_kung_cla_adder_if.sv
// Operand/result bundle for the hybrid Brent-Kung/CLA adder.
// The master drives the operands; the slave (adder) returns the registered result.
interface hybrid_brent_kung_cla_adder_if #(
  parameter int N = 16
);
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic [N-1:0] Sum;
  logic         Cout;

  modport master (
    output A, B, Cin,
    input  Sum, Cout
  );

  modport slave (
    input  A, B, Cin,
    output Sum, Cout
  );
endinterface

// File: rtl/hybrid_brent_kung_cla_adder.sv
// Registered N-bit adder: CLA inside each group, Brent-Kung prefix across groups.
// Cin is folded into group 0, so prefix slot k yields the carry out of group k.
module hybrid_brent_kung_cla_adder #(
  parameter int N          = 16,
  parameter int GROUP_SIZE = 4
) (
  input logic                           clk,
  input logic                           rst,
  hybrid_brent_kung_cla_adder_if.slave  bus
);

  localparam int M   = N / GROUP_SIZE;
  localparam int LOG = (M > 1) ? $clog2(M) : 0;
  localparam int L   = 1 << LOG;

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N-1:0] c;
  logic [M-1:0] gg;
  logic [M-1:0] gp;
  logic [L-1:0] pg;
  logic [L-1:0] pp;
  logic [M:0]   gc;

  logic [N-1:0] sum_d;
  logic [N-1:0] sum_q;
  logic         cout_d;
  logic         cout_q;

  always_comb begin : grp
    logic gterm;
    g     = bus.A & bus.B;
    p     = bus.A ^ bus.B;
    gg    = '0;
    gp    = '0;
    gterm = 1'b0;
    for (int k = 0; k < M; k++) begin
      gp[k] = 1'b1;
      for (int j = 0; j < GROUP_SIZE; j++) begin
        gp[k] = gp[k] & p[k*GROUP_SIZE+j];
        gterm = g[k*GROUP_SIZE+j];
        for (int m = j + 1; m < GROUP_SIZE; m++)
          gterm = gterm & p[k*GROUP_SIZE+m];
        gg[k] = gg[k] | gterm;
      end
    end
  end

  // Padding slots carry (G=0,P=0) and never reach a real group's carry.
  always_comb begin : pfx
    pg        = '0;
    pp        = '0;
    pg[M-1:0] = gg;
    pp[M-1:0] = gp;
    pg[0]     = gg[0] | (gp[0] & bus.Cin);
    pp[0]     = 1'b0;
    for (int d = 0; d < LOG; d++) begin
      for (int i = (2 << d) - 1; i < L; i += (2 << d)) begin
        pg[i] = pg[i] | (pp[i] & pg[i-(1<<d)]);
        pp[i] = pp[i] & pp[i-(1<<d)];
      end
    end
    for (int d = LOG - 2; d >= 0; d--) begin
      for (int i = (3 << d) - 1; i < L; i += (2 << d)) begin
        pg[i] = pg[i] | (pp[i] & pg[i-(1<<d)]);
        pp[i] = pp[i] & pp[i-(1<<d)];
      end
    end
    gc[0]   = bus.Cin;
    gc[M:1] = pg[M-1:0];
  end

  // Every bit carry is a flat sum of products from the group carry-in.
  always_comb begin : cla
    logic cterm;
    c     = '0;
    cterm = 1'b0;
    for (int k = 0; k < M; k++) begin
      for (int j = 0; j < GROUP_SIZE; j++) begin
        cterm = gc[k];
        for (int m = 0; m < j; m++)
          cterm = cterm & p[k*GROUP_SIZE+m];
        c[k*GROUP_SIZE+j] = cterm;
        for (int m = 0; m < j; m++) begin
          cterm = g[k*GROUP_SIZE+m];
          for (int q = m + 1; q < j; q++)
            cterm = cterm & p[k*GROUP_SIZE+q];
          c[k*GROUP_SIZE+j] = c[k*GROUP_SIZE+j] | cterm;
        end
      end
    end
  end

  assign sum_d  = p ^ c;
  assign cout_d = gc[M];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign bus.Sum  = sum_q;
  assign bus.Cout = cout_q;

endmodule

// File: tb/tb_hybrid_brent_kung_cla_adder.sv
// Bench for hybrid_brent_kung_cla_adder: directed cases plus random
// regression on four width/group configurations against plain arithmetic.
module tb_hybrid_brent_kung_cla_adder;

  logic clk = 1'b0;
  logic rst;
  int   errs   = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hybrid_brent_kung_cla_adder_if #(.N(16)) if16 ();
  hybrid_brent_kung_cla_adder_if #(.N(8))  if8  ();
  hybrid_brent_kung_cla_adder_if #(.N(32)) if32 ();
  hybrid_brent_kung_cla_adder_if #(.N(12)) if12 ();

  hybrid_brent_kung_cla_adder #(.N(16), .GROUP_SIZE(4)) u16 (
    .clk(clk), .rst(rst), .bus(if16));
  hybrid_brent_kung_cla_adder #(.N(8), .GROUP_SIZE(2)) u8 (
    .clk(clk), .rst(rst), .bus(if8));
  hybrid_brent_kung_cla_adder #(.N(32), .GROUP_SIZE(4)) u32 (
    .clk(clk), .rst(rst), .bus(if32));
  hybrid_brent_kung_cla_adder #(.N(12), .GROUP_SIZE(4)) u12 (
    .clk(clk), .rst(rst), .bus(if12));

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] golden(input int n, input logic [63:0] a,
                                         input logic [63:0] b, input logic ci);
    logic [63:0] s;
    s = a + b + 64'(ci);
    return s & ((64'd1 << (n + 1)) - 64'd1);
  endfunction

  logic [15:0] va [6];
  logic [15:0] vb [6];
  logic        vc [6];
  logic [16:0] ve [6];

  logic [16:0] e16;
  logic [8:0]  e8;
  logic [32:0] e32;
  logic [12:0] e12;
  logic        r_at_edge;

  task automatic step();
    r_at_edge = rst;
    e16 = 17'(golden(16, 64'(if16.A), 64'(if16.B), if16.Cin));
    e8  = 9'(golden(8, 64'(if8.A), 64'(if8.B), if8.Cin));
    e32 = 33'(golden(32, 64'(if32.A), 64'(if32.B), if32.Cin));
    e12 = 13'(golden(12, 64'(if12.A), 64'(if12.B), if12.Cin));
    if (r_at_edge) begin
      e16 = '0; e8 = '0; e32 = '0; e12 = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_n16"}, 64'({if16.Cout, if16.Sum}), 64'(e16));
    chk({tag, "_n8"},  64'({if8.Cout, if8.Sum}),   64'(e8));
    chk({tag, "_n32"}, 64'({if32.Cout, if32.Sum}), 64'(e32));
    chk({tag, "_n12"}, 64'({if12.Cout, if12.Sum}), 64'(e12));
  endtask

  task automatic drive_rand();
    if16.A = 16'($urandom); if16.B = 16'($urandom); if16.Cin = 1'($urandom);
    if8.A  = 8'($urandom);  if8.B  = 8'($urandom);  if8.Cin  = 1'($urandom);
    if32.A = $urandom;      if32.B = $urandom;      if32.Cin = 1'($urandom);
    if12.A = 12'($urandom); if12.B = 12'($urandom); if12.Cin = 1'($urandom);
  endtask

  initial begin
    va[0] = 16'hFFFF; vb[0] = 16'h0001; vc[0] = 1'b0; ve[0] = 17'h10000;
    va[1] = 16'hFFFF; vb[1] = 16'h0000; vc[1] = 1'b1; ve[1] = 17'h10000;
    va[2] = 16'h000F; vb[2] = 16'h0001; vc[2] = 1'b0; ve[2] = 17'h00010;
    va[3] = 16'h0FFF; vb[3] = 16'h0001; vc[3] = 1'b0; ve[3] = 17'h01000;
    va[4] = 16'hFFFF; vb[4] = 16'hFFFF; vc[4] = 1'b1; ve[4] = 17'h1FFFF;
    va[5] = 16'h0000; vb[5] = 16'h0000; vc[5] = 1'b0; ve[5] = 17'h00000;

    if8.A = '1;  if8.B = '1;  if8.Cin = 1'b1;
    if32.A = '1; if32.B = '1; if32.Cin = 1'b1;
    if12.A = '1; if12.B = '1; if12.Cin = 1'b1;
    if16.A = 16'h1234; if16.B = 16'h4321; if16.Cin = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_n16", 64'({if16.Cout, if16.Sum}), 64'h0);
    chk("reset_n8",  64'({if8.Cout, if8.Sum}),   64'h0);
    chk("reset_n32", 64'({if32.Cout, if32.Sum}), 64'h0);
    chk("reset_n12", 64'({if12.Cout, if12.Sum}), 64'h0);

    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("release", 64'({if16.Cout, if16.Sum}), 64'h05555);

    for (int i = 0; i < 6; i++) begin
      if16.A = va[i]; if16.B = vb[i]; if16.Cin = vc[i];
      @(posedge clk);
      #1;
      chk($sformatf("dir%0d", i), 64'({if16.Cout, if16.Sum}), 64'(ve[i]));
    end

    if16.A = 16'hABCD; if16.B = 16'h1111; if16.Cin = 1'b1;
    #2;
    chk("hold", 64'({if16.Cout, if16.Sum}), 64'(ve[5]));

    for (int i = 0; i < 160; i++) begin
      drive_rand();
      rst = (i == 70 || i == 71);
      step();
      check_all($sformatf("rnd%0d", i));
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/hybrid_brent_kung_cla_adder.md
# hybrid_brent_kung_cla_adder

N-bit two-operand adder with carry-in. Carry generation is hybrid: carry-lookahead (CLA) inside each GROUP_SIZE-bit group, and a Brent-Kung parallel-prefix tree across groups. Sum and carry-out are registered. It is a drop-in arithmetic datapath element, parameterised for width and group size, for use wherever a fast registered adder is needed.

## Interface
- N, default 16: operand and sum width in bits; must be a positive multiple of GROUP_SIZE.
- GROUP_SIZE, default 4: bits per CLA group; must be ≥1 and divide N.

- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- A  input  N  operand A, unsigned.
- B  input  N  operand B, unsigned.
- Cin  input  1  carry into bit 0.
- Sum  output  N  registered (A + B + Cin) mod 2^N.
- Cout  output  1  registered carry out of bit N-1, i.e. bit N of A + B + Cin.

## Operation
- Bit level: g[i] = A[i] & B[i], p[i] = A[i] ^ B[i].
- Group level, for each group k = 0 … N/GROUP_SIZE-1: compute group generate GG[k] and group propagate GP[k] with CLA equations over that group's bits.
- Inter-group carries: a Brent-Kung prefix network combines (GG, GP) pairs with the operator (g1,p1)∘(g0,p0) = (g1 | p1&g0, p1&p0).
  - Up-sweep over log2 levels, then down-sweep.
  - Cin is folded in as the group-(-1) generate term.
  - The network produces the carry into every group plus the final carry.
- Group count that is not a power of two: pad to the next power of two with (G=0, P=0) entries. Padding must not affect the result.
- Intra-group carries: c[j+1] = g[j] | p[j]&c[j], expanded in full lookahead form from the group carry-in. No rippling inside the group.
- Sum[i] = p[i] ^ c[i]; Cout = carry out of the last group.
- Result must equal the full-width unsigned sum A + B + Cin (N+1 bits) for all inputs, including all-ones operands and Cin=1.
- All arithmetic is unsigned. No overflow flag; Cout is the only carry indication.

## Timing
- Combinational adder core; output register stage on Sum and Cout.
- Latency 1 cycle. A, B and Cin present before rising edge t produce Sum/Cout valid after edge t.
- Throughput: one new operation per cycle. No handshake; inputs are sampled every edge.
- Reset at a rising edge with rst=1: Sum=0, Cout=0, regardless of inputs.
- rst has priority over the data path.
- First valid result appears at the first edge with rst=0.
- Reset asserted mid-stream: the result that would have been captured at that edge is discarded. Outputs read 0 until one edge after rst deasserts.
- Outputs hold their value between edges. Input changes between edges have no effect until the next edge.

## Test plan
Use N=16, GROUP_SIZE=4 unless stated. Check each result one cycle after the inputs are applied.
- Reset: rst=1 with A=0x1234, B=0x4321, Cin=0 → Sum=0x0000, Cout=0. Release rst → next edge Sum=0x5555, Cout=0.
- Full-width propagate: A=0xFFFF, B=0x0001, Cin=0 → Sum=0x0000, Cout=1. Then A=0xFFFF, B=0x0000, Cin=1 → Sum=0x0000, Cout=1.
- Group boundary carries: A=0x000F, B=0x0001, Cin=0 → Sum=0x0010, Cout=0. Then A=0x0FFF, B=0x0001, Cin=0 → Sum=0x1000, Cout=0.
- Maximum operands: A=0xFFFF, B=0xFFFF, Cin=1 → Sum=0xFFFF, Cout=1. Then A=0, B=0, Cin=0 → Sum=0, Cout=0.
- Random regression:
  - Apply 100+ random A/B/Cin vectors back-to-back, one per cycle.
  - Each result must equal the golden (A + B + Cin)[N:0] from one cycle earlier.
  - Zero mismatches allowed.
- Parameter sweep: repeat the random test with N=8/GROUP_SIZE=2, N=32/GROUP_SIZE=4 and N=12/GROUP_SIZE=4 (non-power-of-two group count). All must match the golden model exactly.
